fifo_arb_ctrl: RTL and testbench
================================

Name: fifo_arb_ctrl

Overview:
Round-robin write arbiter and sequencing controller for the team's single-entry buffer (wr_e/wr_data/rd_e/rd_data/busy interface).
- Shares the buffer between N_REQ producers.
- Presents a valid/ready consumer interface.
- Tags each stored word with its source ID.
- Keeps a shadow occupancy state to flag protocol mismatches.
- Sits between producer blocks and one buffer instance; buffer rd_data routes to the consumer outside this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 2, data width, matches buffer WIDTH
ID_W, 2, source ID width, must satisfy 2**ID_W >= N_REQ
CNT_W, 8, accepted-word counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester write request
req_data  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot grant; write accepted in the cycle gnt[i]=1
buf_wr_e  out  1  to buffer wr_e
buf_wr_data  out  WIDTH  to buffer wr_data
buf_rd_e  out  1  to buffer rd_e
buf_busy  in  1  from buffer busy
out_valid  out  1  consumer: buffer holds a word
out_ready  in  1  consumer accepts word
out_id  out  ID_W  source ID of stored word
acc_cnt  out  CNT_W  count of accepted writes, wraps
err  out  1  sticky protocol-mismatch flag

Behaviour:
- Reset (async assert, sync to clk on release):
  - state=EMPTY, rr_ptr=0, out_id=0, acc_cnt=0, err=0.
  - Outputs gnt, buf_wr_e and buf_rd_e evaluate to 0 while rst=1.
- FSM states: EMPTY, FULL (shadow of buffer occupancy).
- out_valid = (state==FULL).
- buf_rd_e = out_valid & out_ready (combinational). Buffer rd_data is valid in that same cycle.
- can_wr = (state==EMPTY) | buf_rd_e.
  - A write is allowed into an empty slot, or into a full slot being drained the same cycle (replace).
  - A write and a read together in EMPTY are never issued.
- Arbitration (combinational):
  - Scan req starting at index rr_ptr, wrapping modulo N_REQ; the first set bit wins.
  - gnt = onehot(winner) when any req & can_wr, else 0.
- buf_wr_e = |gnt.
- buf_wr_data = req_data slice of the winner. When no grant it is don't-care; drive 0.
- On a clock edge with a grant to winner w:
  - rr_ptr <= (w+1) mod N_REQ.
  - out_id <= w.
  - acc_cnt <= acc_cnt+1, wrapping at 2**CNT_W.
- With no grant, rr_ptr, out_id and acc_cnt hold.
- Transitions:
  - EMPTY: write -> FULL.
  - FULL: read only -> EMPTY; read+write -> FULL (new word and id); neither -> FULL; write without read cannot occur.
- Latency:
  - A word granted in cycle t is visible as out_valid in t+1.
  - Max throughput is 1 word/cycle with continuous out_ready.
- Fairness: a continuously requesting producer is granted within N_REQ accepted writes.
- Requester protocol: requesters may drop req at any time; a grant is only meaningful in the cycle issued.
- err:
  - Set when buf_busy != (state==FULL) on a clock edge, checked from the first edge after reset release.
  - Sticky until rst.
  - The FSM still follows its own shadow state, not buf_busy.
- Reset mid-operation: any stored word is abandoned; out_valid drops immediately.

Decomposition:
- Shared package: FSM state typedef (EMPTY/FULL) and the ID_W sizing check.
- One natural sub-module: rr_arbiter. It takes a N_REQ request vector, a pointer and an enable, and returns a one-hot grant plus the winner index.
- The FSM, tag, counter and error logic stay in fifo_arb_ctrl.

Test Plan:
- Reset then idle (req=0): gnt=0, out_valid=0, acc_cnt=0, err=0; buf_busy tied to a real buffer stays 0.
- req=4'b1111, out_ready=1, 8 cycles:
  - Grants rotate 0,1,2,3,0,1,2,3.
  - out_id one cycle later follows the same sequence.
  - acc_cnt=8.
- req=4'b0101, out_ready=0:
  - Requester 0 is granted once; state goes FULL and gnt=0 thereafter.
  - Raise out_ready: buf_rd_e=1 and requester 2 is granted the same cycle (replace); out_id=2 next cycle.
- Single word from requester 3 (data 2'b10), out_ready raised two cycles later: the buffer returns 2'b10 with buf_rd_e=1, then out_valid=0.
- Force buf_busy=1 while state=EMPTY for one cycle: err=1 and stays 1 until rst pulse; grant behaviour unchanged.
- Assert rst asynchronously mid-cycle while FULL: out_valid, gnt and acc_cnt drop to 0 without waiting for clk. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/fifo_arb_ctrl_pkg.sv
// Shared types and sizing helpers for the
// round-robin buffer write arbiter.
package fifo_arb_ctrl_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic bit id_w_fits(
        input int n_req,
        input int id_w
    );
        return (2 ** id_w) >= n_req;
    endfunction

endpackage

// File: rtl/fifo_arb_ctrl_if.sv
// Producer, buffer and consumer signals
// of the arbiter bundled as one interface.
interface fifo_arb_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 2,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic                   buf_wr_e;
    logic [WIDTH-1:0]       buf_wr_data;
    logic                   buf_rd_e;
    logic                   buf_busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_W-1:0]        out_id;
    logic [CNT_W-1:0]       acc_cnt;
    logic                   err;

    modport master (
        input  req,
        input  req_data,
        input  buf_busy,
        input  out_ready,
        output gnt,
        output buf_wr_e,
        output buf_wr_data,
        output buf_rd_e,
        output out_valid,
        output out_id,
        output acc_cnt,
        output err
    );

    modport slave (
        output req,
        output req_data,
        output buf_busy,
        output out_ready,
        input  gnt,
        input  buf_wr_e,
        input  buf_wr_data,
        input  buf_rd_e,
        input  out_valid,
        input  out_id,
        input  acc_cnt,
        input  err
    );

endinterface

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set
// request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int   j;
        logic hit;
        j   = 0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit = 1'b1;
                idx = IDX_W'(j);
            end
        end
        any = hit & en;
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Round-robin write arbiter and sequencer for a
// single-entry buffer, with shadow occupancy check.
module fifo_arb_ctrl
    import fifo_arb_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 2,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    fifo_arb_ctrl_if.master bus
);

    if (!id_w_fits(N_REQ, ID_W)) begin : g_id_chk
        $error("ID_W too narrow for N_REQ");
    end

    state_e            state;
    state_e            state_nx;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   ptr_nx;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   out_id_q;
    logic [CNT_W-1:0]  acc_cnt_q;
    logic              err_q;
    logic [N_REQ-1:0]  gnt;
    logic              wr;
    logic              rd;
    logic              can_wr;
    logic              arb_en;

    // Grants are masked while reset is held so
    // the buffer never sees a write during reset.
    assign arb_en = can_wr & ~rst;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req (bus.req),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (gnt),
        .idx (win),
        .any (wr)
    );

    always_comb begin
        rd       = (state == FULL) & bus.out_ready;
        can_wr   = (state == EMPTY) | rd;
        ptr_nx   = win + 1'b1;
        if (int'(win) == N_REQ - 1) begin
            ptr_nx = '0;
        end
        state_nx = state;
        unique case (state)
            EMPTY: if (wr) state_nx = FULL;
            FULL:  if (rd && !wr) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        bus.buf_wr_data = '0;
        if (wr) begin
            bus.buf_wr_data =
                bus.req_data[int'(win)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            rr_ptr    <= '0;
            out_id_q  <= '0;
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr) begin
                rr_ptr    <= ptr_nx;
                out_id_q  <= win;
                acc_cnt_q <= acc_cnt_q + 1'b1;
            end
            if (bus.buf_busy != (state == FULL)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.buf_wr_e  = wr;
    assign bus.buf_rd_e  = rd;
    assign bus.out_valid = (state == FULL);
    assign bus.out_id    = out_id_q;
    assign bus.acc_cnt   = acc_cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: reference model with
// per-cycle compare plus directed literal checks.
module tb_fifo_arb_ctrl;

    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy_force = 1'b0;

    fifo_arb_ctrl_if #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (2),
        .CNT_W (8)
    ) bus ();

    fifo_arb_ctrl #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (2),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm,
                       input int act,
                       input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    // Single-entry buffer the controller drives.
    logic         bb_busy;
    logic [W-1:0] bb_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bb_busy <= 1'b0;
            bb_data <= '0;
        end else if (bus.buf_wr_e) begin
            bb_busy <= 1'b1;
            bb_data <= bus.buf_wr_data;
        end else if (bus.buf_rd_e) begin
            bb_busy <= 1'b0;
        end
    end

    assign bus.buf_busy = bb_busy | busy_force;

    // Reference model: occupancy, pointer, tag,
    // count and error kept as plain integers.
    int m_full = 0;
    int m_ptr  = 0;
    int m_id   = 0;
    int m_cnt  = 0;
    int m_err  = 0;

    function automatic int pick(input logic [N-1:0] r,
                                input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int exp_win();
        int w;
        bit rd;
        rd = (m_full != 0) && bus.out_ready;
        w  = pick(bus.req, m_ptr);
        if (w >= 0 && (m_full == 0 || rd)) return w;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = 0;
            m_ptr  = 0;
            m_id   = 0;
            m_cnt  = 0;
            m_err  = 0;
        end else begin : upd
            int w;
            bit rd;
            rd = (m_full != 0) && bus.out_ready;
            w  = exp_win();
            if (int'(bus.buf_busy) != m_full) m_err = 1;
            if (w >= 0) begin
                m_ptr  = (w + 1) % N;
                m_id   = w;
                m_cnt  = (m_cnt + 1) % 256;
                m_full = 1;
            end else if (rd) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin : cmp
            int w;
            int eg;
            int ed;
            w  = exp_win();
            eg = (w >= 0) ? (1 << w) : 0;
            ed = (w >= 0) ? int'((bus.req_data >> (W*w)) & 2'b11) : 0;
            chk("m_gnt", int'(bus.gnt), eg);
            chk("m_wr_e", int'(bus.buf_wr_e), int'(w >= 0));
            chk("m_wr_data", int'(bus.buf_wr_data), ed);
            chk("m_rd_e", int'(bus.buf_rd_e),
                int'(m_full != 0 && bus.out_ready));
            chk("m_out_valid", int'(bus.out_valid), m_full);
            chk("m_out_id", int'(bus.out_id), m_id);
            chk("m_acc_cnt", int'(bus.acc_cnt), m_cnt);
            chk("m_err", int'(bus.err), m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_data  = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        #1;
        chk("idle_gnt", int'(bus.gnt), 0);
        chk("idle_valid", int'(bus.out_valid), 0);
        chk("idle_cnt", int'(bus.acc_cnt), 0);
        chk("idle_err", int'(bus.err), 0);
        chk("idle_busy", int'(bus.buf_busy), 0);
        step();

        // All four requesting, consumer always ready
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rot_gnt", int'(bus.gnt), 1 << (i % 4));
            step();
            chk("rot_id", int'(bus.out_id), i % 4);
        end
        bus.req = '0;
        chk("rot_cnt", int'(bus.acc_cnt), 8);
        step();

        // Consumer stalled, then replace on drain
        bus.out_ready = 1'b0;
        bus.req       = 4'b0101;
        #1;
        chk("st_gnt0", int'(bus.gnt), 4'b0001);
        step();
        chk("st_full", int'(bus.out_valid), 1);
        chk("st_hold", int'(bus.gnt), 0);
        step();
        chk("st_hold2", int'(bus.gnt), 0);
        bus.out_ready = 1'b1;
        #1;
        chk("rep_rd", int'(bus.buf_rd_e), 1);
        chk("rep_gnt", int'(bus.gnt), 4'b0100);
        step();
        chk("rep_id", int'(bus.out_id), 2);
        chk("rep_cnt", int'(bus.acc_cnt), 10);
        bus.req = '0;
        step();

        // Single word from requester 3, late read
        bus.out_ready = 1'b0;
        bus.req_data  = {2'b10, 2'd2, 2'd1, 2'd0};
        bus.req       = 4'b1000;
        #1;
        chk("one_gnt", int'(bus.gnt), 4'b1000);
        step();
        bus.req = '0;
        step();
        bus.out_ready = 1'b1;
        #1;
        chk("one_rd", int'(bus.buf_rd_e), 1);
        chk("one_data", int'(bb_data), 2'b10);
        chk("one_id", int'(bus.out_id), 3);
        step();
        chk("one_empty", int'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Busy asserted while shadow says empty
        busy_force = 1'b1;
        step();
        busy_force = 1'b0;
        chk("err_set", int'(bus.err), 1);
        bus.req       = 4'b0010;
        bus.out_ready = 1'b1;
        #1;
        chk("err_gnt", int'(bus.gnt), 4'b0010);
        step();
        bus.req = '0;
        step();
        chk("err_sticky", int'(bus.err), 1);

        // Asynchronous reset while holding a word
        bus.out_ready = 1'b0;
        bus.req       = 4'b0001;
        step();
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        chk("pre_gnt", int'(bus.gnt), 4'b0010);
        chk("pre_valid", int'(bus.out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", int'(bus.out_valid), 0);
        chk("ar_gnt", int'(bus.gnt), 0);
        chk("ar_cnt", int'(bus.acc_cnt), 0);
        chk("ar_err", int'(bus.err), 0);
        chk("ar_wr_e", int'(bus.buf_wr_e), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rs_gnt", int'(bus.gnt), 4'b0001);
        step();
        chk("rs_id", int'(bus.out_id), 0);
        step();
        bus.req = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
